// File: rtl/trap_controller.sv
// Pre-trap sequencer: records mepc/mcause/mtval on an exception, or fetches mepc on MRET,
// then issues a one-cycle PC redirect. trap_done stays low while a sequence is in flight.
module trap_controller #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned CSR_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [2:0]                trap_status,
  input  logic [XLEN-1:0]           trap_pc,
  input  logic [31:0]               trap_instruction,
  input  logic [XLEN-1:0]           trap_address,
  input  logic [XLEN-1:0]           csr_read_data,
  output logic                      trap_done,
  output logic                      csr_trap_write,
  output logic [CSR_ADDR_WIDTH-1:0] csr_trap_address,
  output logic [XLEN-1:0]           csr_trap_write_data,
  output logic                      trap_redirect,
  output logic [XLEN-1:0]           trap_target
);

  localparam logic [2:0] IDLE         = 3'd0;
  localparam logic [2:0] WRITE_MEPC   = 3'd1;
  localparam logic [2:0] WRITE_MCAUSE = 3'd2;
  localparam logic [2:0] WRITE_MTVAL  = 3'd3;
  localparam logic [2:0] READ_MTVEC   = 3'd4;
  localparam logic [2:0] READ_MEPC    = 3'd5;
  localparam logic [2:0] REDIRECT     = 3'd6;

  localparam logic [2:0] TS_NONE        = 3'd0;
  localparam logic [2:0] TS_ECALL       = 3'd1;
  localparam logic [2:0] TS_EBREAK      = 3'd2;
  localparam logic [2:0] TS_MISAL_INSTR = 3'd3;
  localparam logic [2:0] TS_MISAL_LOAD  = 3'd4;
  localparam logic [2:0] TS_MISAL_STORE = 3'd5;
  localparam logic [2:0] TS_ILLEGAL     = 3'd6;
  localparam logic [2:0] TS_MRET        = 3'd7;

  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MTVEC  = CSR_ADDR_WIDTH'(12'h305);
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MEPC   = CSR_ADDR_WIDTH'(12'h341);
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MCAUSE = CSR_ADDR_WIDTH'(12'h342);
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MTVAL  = CSR_ADDR_WIDTH'(12'h343);

  logic [2:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [3:0]      cause_q, cause_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic [XLEN-1:0] target_q, target_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      cause_q  <= '0;
      tval_q   <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cause_q  <= cause_d;
      tval_q   <= tval_d;
      target_q <= target_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cause_d  = cause_q;
    tval_d   = tval_q;
    target_d = target_q;
    case (state_q)
      IDLE: begin
        if (trap_status == TS_MRET) begin
          state_d = READ_MEPC;
        end else if (trap_status != TS_NONE) begin
          state_d = WRITE_MEPC;
          pc_d    = trap_pc;
          case (trap_status)
            TS_ECALL:       cause_d = 4'd11;
            TS_EBREAK:      cause_d = 4'd3;
            TS_MISAL_INSTR: cause_d = 4'd0;
            TS_MISAL_LOAD:  cause_d = 4'd4;
            TS_MISAL_STORE: cause_d = 4'd6;
            TS_ILLEGAL:     cause_d = 4'd2;
            default:        cause_d = 4'd0;
          endcase
          case (trap_status)
            TS_MISAL_INSTR, TS_MISAL_LOAD, TS_MISAL_STORE: tval_d = trap_address;
            TS_ILLEGAL:                                    tval_d = XLEN'(trap_instruction);
            default:                                       tval_d = '0;
          endcase
        end
      end
      WRITE_MEPC:   state_d = WRITE_MCAUSE;
      WRITE_MCAUSE: state_d = WRITE_MTVAL;
      WRITE_MTVAL:  state_d = READ_MTVEC;
      // Only direct-mode mtvec is supported, so the mode bits are simply dropped.
      READ_MTVEC: begin
        target_d = {csr_read_data[XLEN-1:2], 2'b00};
        state_d  = REDIRECT;
      end
      READ_MEPC: begin
        target_d = {csr_read_data[XLEN-1:2], 2'b00};
        state_d  = REDIRECT;
      end
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    csr_trap_write      = 1'b0;
    csr_trap_address    = '0;
    csr_trap_write_data = '0;
    case (state_q)
      WRITE_MEPC: begin
        csr_trap_write      = 1'b1;
        csr_trap_address    = CSR_MEPC;
        csr_trap_write_data = {pc_q[XLEN-1:2], 2'b00};
      end
      WRITE_MCAUSE: begin
        csr_trap_write      = 1'b1;
        csr_trap_address    = CSR_MCAUSE;
        csr_trap_write_data = XLEN'(cause_q);
      end
      WRITE_MTVAL: begin
        csr_trap_write      = 1'b1;
        csr_trap_address    = CSR_MTVAL;
        csr_trap_write_data = tval_q;
      end
      READ_MTVEC: csr_trap_address = CSR_MTVEC;
      READ_MEPC:  csr_trap_address = CSR_MEPC;
      default: ;
    endcase
  end

  assign trap_done     = ((state_q == IDLE) && (trap_status == TS_NONE)) || (state_q == REDIRECT);
  assign trap_redirect = (state_q == REDIRECT);
  assign trap_target   = target_q;

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller with a tiny CSR read model for mtvec/mepc.
module tb_trap_controller;

  logic        clk;
  logic        reset;
  logic [2:0]  trap_status;
  logic [31:0] trap_pc;
  logic [31:0] trap_instruction;
  logic [31:0] trap_address;
  logic [31:0] csr_read_data;
  logic        trap_done;
  logic        csr_trap_write;
  logic [11:0] csr_trap_address;
  logic [31:0] csr_trap_write_data;
  logic        trap_redirect;
  logic [31:0] trap_target;

  logic [31:0] mtvec_val;
  logic [31:0] mepc_val;
  int unsigned vectors;
  int unsigned errors;

  trap_controller #(
    .XLEN          (32),
    .CSR_ADDR_WIDTH(12)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .trap_status        (trap_status),
    .trap_pc            (trap_pc),
    .trap_instruction   (trap_instruction),
    .trap_address       (trap_address),
    .csr_read_data      (csr_read_data),
    .trap_done          (trap_done),
    .csr_trap_write     (csr_trap_write),
    .csr_trap_address   (csr_trap_address),
    .csr_trap_write_data(csr_trap_write_data),
    .trap_redirect      (trap_redirect),
    .trap_target        (trap_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign csr_read_data = (csr_trap_address == 12'h305) ? mtvec_val :
                         (csr_trap_address == 12'h341) ? mepc_val  : 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Exception sequence; optionally flips trap_status to EBREAK during WRITE_MCAUSE.
  task automatic run_exc(input string nm, input logic [2:0] st, input logic [31:0] pc,
                         input logic [31:0] instr, input logic [31:0] addr,
                         input logic [31:0] exp_cause, input logic [31:0] exp_tval,
                         input logic [31:0] exp_target, input bit inject);
    int lows;
    lows = 0;
    trap_status = st; trap_pc = pc; trap_instruction = instr; trap_address = addr;
    #1;
    check({nm, " detect done"}, 32'(trap_done), 32'd0);
    check({nm, " detect wr"}, 32'(csr_trap_write), 32'd0);
    if (!trap_done) lows++;
    step();
    trap_pc = 32'hDEAD_BEE0; trap_instruction = 32'h0; trap_address = 32'h0;
    check({nm, " mepc wr"}, 32'(csr_trap_write), 32'd1);
    check({nm, " mepc addr"}, 32'(csr_trap_address), 32'h341);
    check({nm, " mepc data"}, csr_trap_write_data, {pc[31:2], 2'b00});
    if (!trap_done) lows++;
    step();
    if (inject) trap_status = 3'd2;
    check({nm, " mcause wr"}, 32'(csr_trap_write), 32'd1);
    check({nm, " mcause addr"}, 32'(csr_trap_address), 32'h342);
    check({nm, " mcause data"}, csr_trap_write_data, exp_cause);
    if (!trap_done) lows++;
    step();
    check({nm, " mtval wr"}, 32'(csr_trap_write), 32'd1);
    check({nm, " mtval addr"}, 32'(csr_trap_address), 32'h343);
    check({nm, " mtval data"}, csr_trap_write_data, exp_tval);
    if (!trap_done) lows++;
    step();
    check({nm, " mtvec wr"}, 32'(csr_trap_write), 32'd0);
    check({nm, " mtvec addr"}, 32'(csr_trap_address), 32'h305);
    check({nm, " mtvec redirect"}, 32'(trap_redirect), 32'd0);
    if (!trap_done) lows++;
    step();
    check({nm, " redirect"}, 32'(trap_redirect), 32'd1);
    check({nm, " target"}, trap_target, exp_target);
    check({nm, " redirect done"}, 32'(trap_done), 32'd1);
    check({nm, " redirect wr"}, 32'(csr_trap_write), 32'd0);
    check({nm, " done low cycles"}, 32'(lows), 32'd5);
    trap_status = 3'd0;
    step();
    check({nm, " idle done"}, 32'(trap_done), 32'd1);
    check({nm, " idle redirect"}, 32'(trap_redirect), 32'd0);
  endtask

  initial begin
    vectors = 0; errors = 0;
    reset = 1'b0; trap_status = 3'd0;
    trap_pc = 32'h0; trap_instruction = 32'h0; trap_address = 32'h0;
    mtvec_val = 32'h0000_0200; mepc_val = 32'h0000_0108;

    repeat (3) @(posedge clk);
    #1;
    check("rst done", 32'(trap_done), 32'd1);
    reset = 1'b1;
    step();
    check("rst done after", 32'(trap_done), 32'd1);
    check("rst wr", 32'(csr_trap_write), 32'd0);
    check("rst addr", 32'(csr_trap_address), 32'd0);
    check("rst data", csr_trap_write_data, 32'd0);
    check("rst redirect", 32'(trap_redirect), 32'd0);
    check("rst target", trap_target, 32'd0);

    run_exc("ecall", 3'd1, 32'h0000_0104, 32'h0, 32'h0, 32'd11, 32'd0, 32'h200, 1'b0);
    run_exc("mload", 3'd4, 32'h0000_0206, 32'h0, 32'h0000_1003, 32'd4, 32'h1003, 32'h200,
            1'b0);
    mtvec_val = 32'h0000_0301;
    run_exc("illegal", 3'd6, 32'h0000_0300, 32'hFFFF_FFFF, 32'h0, 32'd2, 32'hFFFF_FFFF,
            32'h300, 1'b0);
    mtvec_val = 32'h0000_0200;
    run_exc("ebreak", 3'd2, 32'h0000_0010, 32'h1234_5678, 32'h0000_0abc, 32'd3, 32'd0,
            32'h200, 1'b0);
    run_exc("mstore", 3'd5, 32'h0000_0020, 32'h0, 32'h0000_2002, 32'd6, 32'h2002, 32'h200,
            1'b0);
    run_exc("minstr", 3'd3, 32'h0000_0030, 32'h0, 32'h0000_0042, 32'd0, 32'h42, 32'h200,
            1'b0);
    run_exc("ecall inj", 3'd1, 32'h0000_0104, 32'h0, 32'h0, 32'd11, 32'd0, 32'h200, 1'b1);

    // MRET
    trap_status = 3'd7;
    #1;
    check("mret detect done", 32'(trap_done), 32'd0);
    check("mret detect wr", 32'(csr_trap_write), 32'd0);
    step();
    check("mret read addr", 32'(csr_trap_address), 32'h341);
    check("mret read wr", 32'(csr_trap_write), 32'd0);
    check("mret read done", 32'(trap_done), 32'd0);
    step();
    check("mret redirect", 32'(trap_redirect), 32'd1);
    check("mret target", trap_target, 32'h108);
    check("mret done", 32'(trap_done), 32'd1);
    trap_status = 3'd0;
    step();
    check("mret idle redirect", 32'(trap_redirect), 32'd0);

    // Reset during WRITE_MTVAL
    trap_status = 3'd1; trap_pc = 32'h0000_0104;
    step();
    step();
    step();
    check("rstmid mtval wr", 32'(csr_trap_write), 32'd1);
    reset = 1'b0; trap_status = 3'd0;
    #1;
    check("rstmid wr", 32'(csr_trap_write), 32'd0);
    check("rstmid target", trap_target, 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("rstmid hold wr", 32'(csr_trap_write), 32'd0);
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rstmid post wr", 32'(csr_trap_write), 32'd0);
      check("rstmid post done", 32'(trap_done), 32'd1);
      check("rstmid post redirect", 32'(trap_redirect), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
